// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared RV64I definitions for the decode stage: datapath sizes, base opcodes,
// ALUControl and ResultSrc encodings, immediate formats, the ID/EX pipeline
// register layout, and helper functions for immediate generation and the
// funct3/funct7 to ALU-operation mapping.
// Ports: none (package).
// -----------------------------------------------------------------------------
package id_stage_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Everything execute sees; an all-zero value is the bubble.
  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            word;
    logic            illegal;
    result_src_e     result_src;
    alu_ctrl_e       alu_control;
    logic [2:0]      funct3;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                              input imm_type_e  kind);
    logic [XLEN-1:0] imm;
    case (kind)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // SUB only exists in the register-register forms; for the immediate forms
  // bit 30 is part of the immediate unless the op is a right shift.
  function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       allow_sub);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = (allow_sub && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Bundles the decode-stage datapath: fetch-side inputs (PC_D, instruction_D),
// write-back port, ID/EX stall/flush, hazard-unit source indices and all
// registered _E outputs.
// Modports: slave  - the decode stage (consumes _D/_W, produces _E)
//           master - the surrounding pipeline / testbench
// -----------------------------------------------------------------------------
interface id_stage_if;
  import id_stage_pkg::*;

  logic [XLEN-1:0] PC_D;
  logic [31:0]     instruction_D;
  logic            RegWrite_W;
  logic [4:0]      Rd_W;
  logic [XLEN-1:0] Result_W;
  logic            Stall_E;
  logic            Flush_E;

  logic [4:0]      Rs1_D;
  logic [4:0]      Rs2_D;

  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PC_E;
  logic [4:0]      Rs1_E;
  logic [4:0]      Rs2_E;
  logic [4:0]      Rd_E;
  logic            RegWrite_E;
  logic            MemWrite_E;
  logic            MemRead_E;
  logic            Branch_E;
  logic            Jump_E;
  logic            Jalr_E;
  logic            ALUSrcA_E;
  logic            ALUSrcB_E;
  logic            Word_E;
  logic            Illegal_E;
  logic [1:0]      ResultSrc_E;
  logic [3:0]      ALUControl_E;
  logic [2:0]      Funct3_E;

  modport slave (
    input  PC_D, instruction_D, RegWrite_W, Rd_W, Result_W, Stall_E, Flush_E,
    output Rs1_D, Rs2_D, RD1_E, RD2_E, Imm_Ext_E, PC_E, Rs1_E, Rs2_E, Rd_E,
           RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, Jalr_E,
           ALUSrcA_E, ALUSrcB_E, Word_E, Illegal_E, ResultSrc_E,
           ALUControl_E, Funct3_E
  );

  modport master (
    output PC_D, instruction_D, RegWrite_W, Rd_W, Result_W, Stall_E, Flush_E,
    input  Rs1_D, Rs2_D, RD1_E, RD2_E, Imm_Ext_E, PC_E, Rs1_E, Rs2_E, Rd_E,
           RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, Jalr_E,
           ALUSrcA_E, ALUSrcB_E, Word_E, Illegal_E, ResultSrc_E,
           ALUControl_E, Funct3_E
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x XLEN architectural register file, two combinational read ports and one
// write port. x0 reads 0 and ignores writes. A read of the register being
// written back this cycle returns the write-back data directly.
// Ports: clk, reset (async, active-low), we/waddr/wdata (write port),
//        raddr1/raddr2 -> rdata1/rdata2 (read ports).
// -----------------------------------------------------------------------------
module reg_file
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_active;

  assign wr_active = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[waddr] <= wdata;
    end
  end

  // The bypass lets decode see a result written back in the same cycle,
  // so the pipeline needs no extra forwarding path for the W->D distance.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) rdata1 = (wr_active && waddr == raddr1) ? wdata : regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) rdata2 = (wr_active && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// RV64I decode stage: reads operands (with write-back bypass), generates
// sign-extended immediates and control signals, and registers them into the
// ID/EX pipeline register (flush beats stall beats load).
// Ports: clk, reset (async, active-low), bus (id_stage_if.slave) carrying the
//        fetch inputs, write-back port, stall/flush, Rs1_D/Rs2_D and all _E
//        outputs.
// -----------------------------------------------------------------------------
module id_stage
  import id_stage_pkg::*;
(
  input logic        clk,
  input logic        reset,
  id_stage_if.slave  bus
);

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  imm_type_e       imm_type;
  id_ex_t          dec;
  id_ex_t          ex;

  assign instr     = bus.instruction_D;
  assign opcode    = instr[6:0];
  assign bus.Rs1_D = instr[19:15];
  assign bus.Rs2_D = instr[24:20];

  reg_file u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.RegWrite_W),
    .waddr  (bus.Rd_W),
    .wdata  (bus.Result_W),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Register indices, operands, PC and funct3 are always captured; only the
  // control bits depend on the opcode. Unknown opcodes keep bubble controls.
  always_comb begin
    dec      = '0;
    imm_type = IMM_NONE;
    dec.rd1    = rdata1;
    dec.rd2    = rdata2;
    dec.pc     = bus.PC_D;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = instr[14:12];
    case (opcode)
      OPC_LOAD: begin
        imm_type       = IMM_I;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.result_src = RES_MEM;
        dec.alu_src_b  = 1'b1;
        dec.alu_control = ALU_ADD;
      end
      OPC_STORE: begin
        imm_type       = IMM_S;
        dec.mem_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.alu_control = ALU_ADD;
      end
      OPC_OP, OPC_OP_32: begin
        dec.reg_write   = 1'b1;
        dec.word        = (opcode == OPC_OP_32);
        dec.alu_control = alu_from_funct(instr[14:12], instr[30], 1'b1);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        imm_type        = IMM_I;
        dec.reg_write   = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.word        = (opcode == OPC_OP_IMM_32);
        dec.alu_control = alu_from_funct(instr[14:12], instr[30], 1'b0);
      end
      OPC_BRANCH: begin
        imm_type        = IMM_B;
        dec.branch      = 1'b1;
        dec.alu_control = ALU_SUB;
      end
      OPC_JAL: begin
        imm_type       = IMM_J;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_JALR: begin
        imm_type        = IMM_I;
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.jalr        = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.alu_control = ALU_ADD;
        dec.result_src  = RES_PC4;
      end
      OPC_LUI: begin
        imm_type        = IMM_U;
        dec.reg_write   = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.alu_control = ALU_PASSB;
      end
      OPC_AUIPC: begin
        imm_type        = IMM_U;
        dec.reg_write   = 1'b1;
        dec.alu_src_a   = 1'b1;
        dec.alu_src_b   = 1'b1;
        dec.alu_control = ALU_ADD;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = gen_imm(instr, imm_type);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex <= '0;
    end else if (bus.Flush_E) begin
      ex <= '0;
    end else if (!bus.Stall_E) begin
      ex <= dec;
    end
  end

  assign bus.RD1_E        = ex.rd1;
  assign bus.RD2_E        = ex.rd2;
  assign bus.Imm_Ext_E    = ex.imm;
  assign bus.PC_E         = ex.pc;
  assign bus.Rs1_E        = ex.rs1;
  assign bus.Rs2_E        = ex.rs2;
  assign bus.Rd_E         = ex.rd;
  assign bus.RegWrite_E   = ex.reg_write;
  assign bus.MemWrite_E   = ex.mem_write;
  assign bus.MemRead_E    = ex.mem_read;
  assign bus.Branch_E     = ex.branch;
  assign bus.Jump_E       = ex.jump;
  assign bus.Jalr_E       = ex.jalr;
  assign bus.ALUSrcA_E    = ex.alu_src_a;
  assign bus.ALUSrcB_E    = ex.alu_src_b;
  assign bus.Word_E       = ex.word;
  assign bus.Illegal_E    = ex.illegal;
  assign bus.ResultSrc_E  = ex.result_src;
  assign bus.ALUControl_E = ex.alu_control;
  assign bus.Funct3_E     = ex.funct3;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Directed self-checking bench for id_stage: reset, register write/read,
// write-back bypass, x0 behaviour, immediate formats, opcode decode,
// stall/flush priority, illegal opcodes and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  id_stage_if ifc ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc,
                               input logic wEn, input logic [4:0] wRd,
                               input logic [63:0] wData, input logic stall,
                               input logic flush);
    ifc.instruction_D = instr;
    ifc.PC_D          = pc;
    ifc.RegWrite_W    = wEn;
    ifc.Rd_W          = wRd;
    ifc.Result_W      = wData;
    ifc.Stall_E       = stall;
    ifc.Flush_E       = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic anyOutputSet();
    return |{ifc.RD1_E, ifc.RD2_E, ifc.Imm_Ext_E, ifc.PC_E, ifc.Rs1_E,
             ifc.Rs2_E, ifc.Rd_E, ifc.RegWrite_E, ifc.MemWrite_E,
             ifc.MemRead_E, ifc.Branch_E, ifc.Jump_E, ifc.Jalr_E,
             ifc.ALUSrcA_E, ifc.ALUSrcB_E, ifc.Word_E, ifc.Illegal_E,
             ifc.ResultSrc_E, ifc.ALUControl_E, ifc.Funct3_E};
  endfunction

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    // Reset held with random inputs, including write-back attempts.
    reset = 1'b0;
    applyStimulus($urandom, {$urandom, $urandom}, 1'b1, 5'd5,
                  {$urandom, $urandom}, 1'b0, 1'b0);
    tick();
    applyStimulus($urandom, {$urandom, $urandom}, 1'b1, 5'($urandom),
                  {$urandom, $urandom}, 1'b0, 1'b0);
    tick();
    checkOutput("reset_all_zero", 64'(anyOutputSet()), 64'd0);
    checkOutput("reset_pc_e", ifc.PC_E, 64'd0);

    // Release reset, read x5 (addi x6,x5,0).
    applyStimulus(32'h00028313, 64'h0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("rs1_d_comb", 64'(ifc.Rs1_D), 64'd5);
    tick();
    checkOutput("x5_after_reset", ifc.RD1_E, 64'd0);
    checkOutput("addi_rd_e", 64'(ifc.Rd_E), 64'd6);

    // Write x5 = 0x1234, then read it back.
    applyStimulus(32'h00000013, 64'h4, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    tick();
    checkOutput("nop_regwrite", 64'(ifc.RegWrite_E), 64'd1);
    checkOutput("nop_rd_e", 64'(ifc.Rd_E), 64'd0);
    applyStimulus(32'h00028313, 64'h8, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("x5_read", ifc.RD1_E, 64'h1234);
    checkOutput("addi0_imm", ifc.Imm_Ext_E, 64'd0);
    checkOutput("addi_alusrcb", 64'(ifc.ALUSrcB_E), 64'd1);
    checkOutput("addi_aluctl", 64'(ifc.ALUControl_E), 64'h0);
    checkOutput("addi_pc_e", ifc.PC_E, 64'h8);

    // Same-cycle bypass on x7, then the stored copy.
    applyStimulus(32'h00038413, 64'hC, 1'b1, 5'd7, 64'hDEAD, 1'b0, 1'b0);
    tick();
    checkOutput("bypass_x7", ifc.RD1_E, 64'hDEAD);
    applyStimulus(32'h00038413, 64'h10, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("stored_x7", ifc.RD1_E, 64'hDEAD);

    // Writes to x0 neither bypass nor stick.
    applyStimulus(32'h00000013, 64'h14, 1'b1, 5'd0, 64'hBEEF, 1'b0, 1'b0);
    tick();
    checkOutput("x0_bypass", ifc.RD1_E, 64'd0);
    applyStimulus(32'h00000013, 64'h18, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("x0_stored", ifc.RD1_E, 64'd0);

    // Immediates.
    applyStimulus(32'hFFF00093, 64'h1C, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("imm_i_neg1", ifc.Imm_Ext_E, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(32'hFE000EE3, 64'h20, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("imm_b_neg4", ifc.Imm_Ext_E, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq_branch", 64'(ifc.Branch_E), 64'd1);
    checkOutput("beq_aluctl", 64'(ifc.ALUControl_E), 64'h1);
    checkOutput("beq_regwrite", 64'(ifc.RegWrite_E), 64'd0);
    applyStimulus(32'h000012B7, 64'h24, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("imm_u_lui", ifc.Imm_Ext_E, 64'h1000);
    checkOutput("lui_aluctl", 64'(ifc.ALUControl_E), 64'hA);

    // sw x6,8(x5), then stall two cycles with different inputs.
    applyStimulus(32'h0062A423, 64'h100, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("sw_memwrite", 64'(ifc.MemWrite_E), 64'd1);
    checkOutput("sw_regwrite", 64'(ifc.RegWrite_E), 64'd0);
    checkOutput("sw_imm_s", ifc.Imm_Ext_E, 64'd8);
    checkOutput("sw_rs2_e", 64'(ifc.Rs2_E), 64'd6);
    checkOutput("sw_funct3", 64'(ifc.Funct3_E), 64'd2);
    checkOutput("sw_rd1", ifc.RD1_E, 64'h1234);
    applyStimulus(32'hFFFFFFFF, 64'h200, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("stall_memwrite", 64'(ifc.MemWrite_E), 64'd1);
    checkOutput("stall_imm", ifc.Imm_Ext_E, 64'd8);
    checkOutput("stall_pc", ifc.PC_E, 64'h100);
    checkOutput("stall_illegal", 64'(ifc.Illegal_E), 64'd0);

    // Flush wins over stall.
    applyStimulus(32'h0062A423, 64'h300, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_bubble", 64'(anyOutputSet()), 64'd0);

    // Illegal opcode.
    applyStimulus(32'hFFFFFFFF, 64'h400, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("ill_flag", 64'(ifc.Illegal_E), 64'd1);
    checkOutput("ill_ctrl", 64'({ifc.RegWrite_E, ifc.MemWrite_E, ifc.Jump_E, ifc.Branch_E}), 64'd0);

    // ld x10,-8(x5)
    applyStimulus(32'hFF82B503, 64'h404, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("ld_memread", 64'(ifc.MemRead_E), 64'd1);
    checkOutput("ld_resultsrc", 64'(ifc.ResultSrc_E), 64'd1);
    checkOutput("ld_imm", ifc.Imm_Ext_E, 64'hFFFF_FFFF_FFFF_FFF8);

    // sub x3,x1,x2
    applyStimulus(32'h402081B3, 64'h408, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("sub_aluctl", 64'(ifc.ALUControl_E), 64'h1);
    checkOutput("sub_alusrcb", 64'(ifc.ALUSrcB_E), 64'd0);

    // jal x1,16
    applyStimulus(32'h010000EF, 64'h40C, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("jal_imm", ifc.Imm_Ext_E, 64'd16);
    checkOutput("jal_ctrl", 64'({ifc.Jump_E, ifc.Jalr_E, ifc.RegWrite_E, ifc.ResultSrc_E}), 64'b10110);

    // sraiw x4,x4,3
    applyStimulus(32'h4032521B, 64'h410, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("sraiw_aluctl", 64'(ifc.ALUControl_E), 64'h7);
    checkOutput("sraiw_word", 64'(ifc.Word_E), 64'd1);

    // auipc x2,1
    applyStimulus(32'h00001117, 64'h414, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("auipc_srca", 64'(ifc.ALUSrcA_E), 64'd1);
    checkOutput("auipc_imm", ifc.Imm_Ext_E, 64'h1000);

    // Asynchronous reset between edges, then register file must be clear.
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 64'(anyOutputSet()), 64'd0);
    #2;
    applyStimulus(32'h00028313, 64'h500, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("x5_cleared", ifc.RD1_E, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
